// File: rtl/tilt_motion_gen_pkg.sv
// Shared constants, direction encoding and tilt magnitude helper for the
// accelerometer-to-movement-pulse converter.
package tilt_motion_pkg;

   localparam int RAW_W   = 9;
   localparam int TILT_W  = 10;
   localparam int LEVEL_W = 2;

   localparam logic [TILT_W-1:0] ACCEL_ZERO = 10'd256;

   localparam int MV_RIGHT = 3;
   localparam int MV_LEFT  = 2;
   localparam int MV_DOWN  = 1;
   localparam int MV_UP    = 0;

   // Reset value 0 means "positive", so a fresh start never looks like a reversal.
   typedef enum logic {
      DIR_POS = 1'b0,
      DIR_NEG = 1'b1
   } dir_e;

   // |t| for a signed 10-bit tilt; -256 yields 256, which still fits 9 bits.
   function automatic logic [RAW_W-1:0] tilt_mag(input logic [TILT_W-1:0] t);
      return t[TILT_W-1] ? RAW_W'(~t + TILT_W'(1)) : t[RAW_W-1:0];
   endfunction

endpackage

// File: rtl/tilt_motion_gen_axis.sv
// One accelerometer axis: offset removal, IIR filter, deadzone/speed level and
// the step counter that turns a steady tilt into periodic one-cycle pulses.
module tilt_axis
   import tilt_motion_pkg::*;
#(
   parameter int FILT_SHIFT    = 2,
   parameter int DEADZONE      = 16,
   parameter int LEVEL_SHIFT   = 5,
   parameter int BASE_INTERVAL = 32,
   parameter int INVERT        = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_tick,
   input  logic               i_enable,
   input  logic [RAW_W-1:0]   i_accel,
   output logic [TILT_W-1:0]  o_tilt,
   output logic [LEVEL_W-1:0] o_level,
   output logic               o_pulse_pos,
   output logic               o_pulse_neg
);

   localparam int             ACC_W = TILT_W + FILT_SHIFT;
   localparam int             CNT_W = $clog2(BASE_INTERVAL + 1);
   localparam logic [RAW_W-1:0] DZ  = RAW_W'(DEADZONE);
   localparam logic           INV   = (INVERT != 0);

   logic signed [TILT_W-1:0] r_s;
   logic signed [ACC_W-1:0]  r_acc;
   logic                     r_t1;
   logic                     r_t2;
   logic [CNT_W-1:0]         r_cnt;
   dir_e                     r_dir;
   logic [LEVEL_W-1:0]       r_level;
   logic                     r_pos;
   logic                     r_neg;

   logic signed [ACC_W-1:0]  w_s_ext;
   logic signed [ACC_W-1:0]  w_acc_next;
   logic [TILT_W-1:0]        w_tilt;
   logic [RAW_W-1:0]         w_mag;
   logic [RAW_W-1:0]         w_excess;
   logic [RAW_W-1:0]         w_lvl_full;
   logic                     w_active;
   dir_e                     w_dir;
   logic [LEVEL_W-1:0]       w_level;
   logic [CNT_W-1:0]         w_interval;
   logic [CNT_W:0]           w_cnt_inc;
   logic                     w_step_ok;
   logic                     w_fire;

   // acc holds tilt << FILT_SHIFT, so adding s and subtracting acc>>>FILT_SHIFT is a 1-pole IIR.
   assign w_s_ext    = ACC_W'(r_s);
   assign w_acc_next = r_acc + w_s_ext - (r_acc >>> FILT_SHIFT);
   assign w_tilt     = TILT_W'(r_acc >>> FILT_SHIFT);

   assign w_mag      = tilt_mag(w_tilt);
   assign w_active   = (w_mag > DZ);
   assign w_dir      = dir_e'(w_tilt[TILT_W-1] ^ INV);
   assign w_excess   = w_mag - DZ;
   assign w_lvl_full = w_excess >> LEVEL_SHIFT;
   assign w_level    = (w_lvl_full > 9'd3) ? 2'd3 : w_lvl_full[LEVEL_W-1:0];

   // Comparing with >= lets a level increase fire at once instead of waiting for a wrap.
   assign w_interval = CNT_W'(BASE_INTERVAL >> w_level);
   assign w_cnt_inc  = {1'b0, r_cnt} + (CNT_W + 1)'(1);
   assign w_step_ok  = i_enable && w_active && (w_dir == r_dir);
   assign w_fire     = w_step_ok && (w_cnt_inc >= {1'b0, w_interval});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s     <= '0;
         r_acc   <= '0;
         r_t1    <= 1'b0;
         r_t2    <= 1'b0;
         r_cnt   <= '0;
         r_dir   <= DIR_POS;
         r_level <= '0;
         r_pos   <= 1'b0;
         r_neg   <= 1'b0;
      end else begin
         r_t1  <= i_tick;
         r_t2  <= r_t1;
         r_pos <= 1'b0;
         r_neg <= 1'b0;
         if (i_tick) begin
            r_s <= $signed({1'b0, i_accel} - ACCEL_ZERO);
         end
         if (r_t1) begin
            r_acc <= w_acc_next;
         end
         if (r_t2) begin
            r_dir   <= w_dir;
            r_level <= w_active ? w_level : '0;
            if (!w_step_ok) begin
               r_cnt <= '0;
            end else if (w_fire) begin
               r_cnt <= '0;
               r_pos <= (w_dir == DIR_POS);
               r_neg <= (w_dir == DIR_NEG);
            end else begin
               r_cnt <= w_cnt_inc[CNT_W-1:0];
            end
         end
      end
   end

   assign o_tilt      = w_tilt;
   assign o_level     = r_level;
   assign o_pulse_pos = r_pos;
   assign o_pulse_neg = r_neg;

endmodule

// File: rtl/tilt_motion_gen.sv
// Tilt-to-movement converter: shared sample tick divider feeding an X and a Y
// axis, with the pulses packed into the ball's {right, left, down, up} input.
module tilt_motion_gen
   import tilt_motion_pkg::*;
#(
   parameter int SAMPLE_DIV    = 100000,
   parameter int FILT_SHIFT    = 2,
   parameter int DEADZONE      = 16,
   parameter int LEVEL_SHIFT   = 5,
   parameter int BASE_INTERVAL = 32,
   parameter int INVERT_X      = 0,
   parameter int INVERT_Y      = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [8:0]  accel_x,
   input  logic [8:0]  accel_y,
   output logic [3:0]  movement,
   output logic [9:0]  tilt_x,
   output logic [9:0]  tilt_y,
   output logic [1:0]  level_x,
   output logic [1:0]  level_y
);

   localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

   logic [DIV_W-1:0] r_div;
   logic             r_tick;

   logic             w_x_pos;
   logic             w_x_neg;
   logic             w_y_pos;
   logic             w_y_neg;
   logic [3:0]       w_movement;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_div  <= '0;
         r_tick <= 1'b0;
      end else begin
         r_tick <= (r_div == DIV_W'(SAMPLE_DIV - 1));
         if (r_div == DIV_W'(SAMPLE_DIV - 1)) begin
            r_div <= '0;
         end else begin
            r_div <= r_div + DIV_W'(1);
         end
      end
   end

   tilt_axis #(
      .FILT_SHIFT    (FILT_SHIFT),
      .DEADZONE      (DEADZONE),
      .LEVEL_SHIFT   (LEVEL_SHIFT),
      .BASE_INTERVAL (BASE_INTERVAL),
      .INVERT        (INVERT_X)
   ) u_axis_x (
      .clk         (clk),
      .rst_n       (reset),
      .i_tick      (r_tick),
      .i_enable    (enable),
      .i_accel     (accel_x),
      .o_tilt      (tilt_x),
      .o_level     (level_x),
      .o_pulse_pos (w_x_pos),
      .o_pulse_neg (w_x_neg)
   );

   tilt_axis #(
      .FILT_SHIFT    (FILT_SHIFT),
      .DEADZONE      (DEADZONE),
      .LEVEL_SHIFT   (LEVEL_SHIFT),
      .BASE_INTERVAL (BASE_INTERVAL),
      .INVERT        (INVERT_Y)
   ) u_axis_y (
      .clk         (clk),
      .rst_n       (reset),
      .i_tick      (r_tick),
      .i_enable    (enable),
      .i_accel     (accel_y),
      .o_tilt      (tilt_y),
      .o_level     (level_y),
      .o_pulse_pos (w_y_pos),
      .o_pulse_neg (w_y_neg)
   );

   // Positive X steers right, positive Y steers up.
   always_comb begin
      w_movement           = '0;
      w_movement[MV_RIGHT] = w_x_pos;
      w_movement[MV_LEFT]  = w_x_neg;
      w_movement[MV_DOWN]  = w_y_neg;
      w_movement[MV_UP]    = w_y_pos;
   end

   assign movement = w_movement;

endmodule

// File: doc/tilt_motion_gen.md
Name: tilt_motion_gen

Overview:
- Sits between AccelerometerCtl and Ball.
- Converts raw 9-bit accelerometer X/Y readings into one-cycle movement pulses, replacing push-button steering of the ball.
- Per axis: periodic sampling, low-pass filtering, deadzone, tilt-proportional step rate.
- Output bit order matches Ball's movement input.

Parameters:
- SAMPLE_DIV, 100000: clk cycles per sample tick (1 kHz at 100 MHz).
- FILT_SHIFT, 2: IIR filter shift; 0 = no filtering.
- DEADZONE, 16: filtered tilt magnitude at or below which the axis is idle.
- LEVEL_SHIFT, 5: excess-over-deadzone divisor (log2) used to pick the speed level.
- BASE_INTERVAL, 32: sample ticks between steps at level 0; level L uses BASE_INTERVAL >> L.
- INVERT_X, 0: swap the left/right sense.
- INVERT_Y, 0: swap the up/down sense.

Ports:
- clk, in, 1: system clock, 100 MHz.
- reset, in, 1: asynchronous, active-low reset.
- enable, in, 1: motion enable; filter runs regardless.
- accel_x, in, 9: raw X, offset binary, 256 = 0 g.
- accel_y, in, 9: raw Y, offset binary, 256 = 0 g.
- movement, out, 4: {right, left, down, up}, one-cycle step pulses.
- tilt_x, out, 10: filtered signed X tilt, for debug/display.
- tilt_y, out, 10: filtered signed Y tilt.
- level_x, out, 2: current X speed level, valid only while X is active.
- level_y, out, 2: current Y speed level, valid only while Y is active.

Behaviour:
- Reset (async, reset = 0): tick divider, filter accumulators, step counters and every output go to 0.
- Tick: divider counts 0..SAMPLE_DIV-1 and asserts tick for one cycle on wrap. Runs continuously, independent of enable.
- Stage 1, cycle t (tick): s = {1'b0, accel} - 256, a signed 10-bit value; range -256..+255. Registered.
- Stage 2, cycle t+1: acc (signed 10+FILT_SHIFT bits) <= acc + s - (acc >>> FILT_SHIFT). Filtered tilt = acc >>> FILT_SHIFT, driven on tilt_x/tilt_y.
- Stage 3, cycle t+2: registered per axis:
  - mag = |tilt| (9-bit unsigned; -256 gives 256).
  - active = mag > DEADZONE.
  - dir = sign of tilt, after applying INVERT_*.
  - level = min((mag - DEADZONE) >> LEVEL_SHIFT, 3).
- Step counter, on the stage-3 tick (t+2), per axis:
  - If !enable, !active, or dir differs from the previous stage-3 dir: counter <= 0, no pulse.
  - Else if counter + 1 >= (BASE_INTERVAL >> level): counter <= 0 and the direction pulse is registered.
  - Else counter <= counter + 1.
- Pulse appears on movement at t+3 and lasts exactly one clk.
- The >= compare means a level increase mid-count fires on the next tick, never waits for a wrap.
- Direction mapping: X positive → right (bit 3), X negative → left (bit 2); Y positive → up (bit 0), Y negative → down (bit 1).
- Per axis, the two opposite bits are never high together. X and Y may pulse in the same cycle (diagonal).
- Interval floor: BASE_INTERVAL >> 3 must be ≥ 1; SAMPLE_DIV ≥ 4 so stages never overlap ticks.
- enable deasserting mid-count: counter clears, no pulse. On reassertion the count restarts from 0.
- Saturation: the accumulator never overflows, since |s| ≤ 256 and acc is sized 10+FILT_SHIFT bits.
- Reset released mid-tick: the divider restarts from 0.

Decomposition:
- Package tilt_motion_pkg holds:
  - ACCEL_ZERO = 256.
  - Movement bit indices MV_RIGHT = 3, MV_LEFT = 2, MV_DOWN = 1, MV_UP = 0.
  - Widths: raw 9, tilt 10, level 2.
- Sub-module tilt_axis contains filter, deadzone/level and step counter. It is instantiated twice (X, Y) and takes an INVERT parameter.
- The top holds the tick divider and output packing.

Test Plan:
- Bench defaults: SAMPLE_DIV = 4, FILT_SHIFT = 0, DEADZONE = 16, LEVEL_SHIFT = 5, BASE_INTERVAL = 32, unless stated otherwise.
- Reset: drive reset = 0 mid-run with accel_x = 400 → movement, tilt_x, tilt_y and levels are 0 in the same cycle (asynchronous). After release, no pulse for at least 3 ticks.
- Level tilt: accel_x = accel_y = 256, enable = 1, for 500 ticks → movement stays 4'b0000 and tilt_x = 0.
- Slow right: accel_x = 296 → tilt_x = 40, level_x = 0. Right pulse (movement = 4'b1000) every 32 ticks (128 clk), each exactly 1 cycle wide.
- Fast left: accel_x = 106 → tilt_x = -150, level_x = 3. Left pulse (4'b0100) every 4 ticks. Switching to accel_x = 406 restarts the count, and the first right pulse follows 4 ticks later.
- Filter step (FILT_SHIFT = 2): accel_y 256 → 320 → tilt_y = 16, 28, 37 after ticks 1..3. No up pulse before tilt_y > 16.
- Enable gating: accel_y = 100 with enable toggled 0 for 10 ticks → no pulses while low. First down pulse (4'b0010) comes a full interval after re-enable. tilt_y keeps tracking throughout.
